// File: rtl/commit_trace.sv
// commit_trace: retirement trace FIFO and performance counters downstream of the core.
// Define COMMIT_TRACE_TIMESTAMP_EN to store a cycle-count timestamp with each entry.
module commit_trace #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              instr_i,
  input  logic                     insn_vld_i,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_pc,
  output logic [31:0]              trace_instr,
  output logic [1:0]               trace_kind,
  output logic [CNT_W-1:0]         trace_ts,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         instret_cnt,
  output logic [CNT_W-1:0]         illegal_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [1:0] kind_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [31:0] last_pc;
  logic sync_pending, cap, full, pop, push, drop;
  logic [1:0] kind;
  always_comb begin
    cap = en & (~insn_vld_i | sync_pending | (pc_i != last_pc + 32'd4));
    kind = ~insn_vld_i ? 2'b10 : sync_pending ? 2'b00 : 2'b01;
    full = count == (AW+1)'(DEPTH);
    pop = trace_valid & trace_ready;
    push = cap & (~full | pop);
    drop = cap & full & ~pop;
  end
  assign trace_valid = count != '0;
  assign fifo_count = count;
  assign trace_pc = pc_mem[rd_ptr];
  assign trace_instr = instr_mem[rd_ptr];
  assign trace_kind = kind_mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      last_pc <= '0;
      sync_pending <= 1'b1;
      overflow <= 1'b0;
      cycle_cnt <= '0;
      instret_cnt <= '0;
      illegal_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      last_pc <= en ? pc_i : last_pc;
      // An illegal capture must not consume the pending sync point
      sync_pending <= ~en | (sync_pending & ~insn_vld_i);
      overflow <= ~clr & (overflow | drop);
      cycle_cnt <= clr ? '0 : cycle_cnt + CNT_W'(en);
      instret_cnt <= clr ? '0 : instret_cnt + CNT_W'(en & insn_vld_i);
      illegal_cnt <= clr ? '0 : illegal_cnt + CNT_W'(en & ~insn_vld_i);
      drop_cnt <= clr ? '0 : drop_cnt + CNT_W'(drop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= pc_i;
      instr_mem[wr_ptr] <= instr_i;
      kind_mem[wr_ptr] <= kind;
    end
  end
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (push) ts_mem[wr_ptr] <= cycle_cnt;
  end
  assign trace_ts = ts_mem[rd_ptr];
`else
  assign trace_ts = '0;
`endif
endmodule

// File: tb/tb_commit_trace.sv
// tb_commit_trace: directed steps with a scoreboard queue of expected trace entries.
module tb_commit_trace;
  localparam int DEPTH = 16;
  localparam int CNT_W = 32;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0] kind;
    logic [31:0] ts;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] instr_i = '0;
  logic insn_vld_i = 1'b1;
  logic trace_ready = 1'b0;
  logic trace_valid, overflow;
  logic [31:0] trace_pc, trace_instr;
  logic [1:0] trace_kind;
  logic [CNT_W-1:0] trace_ts, cycle_cnt, instret_cnt, illegal_cnt, drop_cnt;
  logic [$clog2(DEPTH):0] fifo_count;
  ent_t q[$];
  int n_asrt = 0;
  int n_fail = 0;
  logic [31:0] cyc = '0;
  commit_trace #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .pc_i(pc_i), .instr_i(instr_i),
    .insn_vld_i(insn_vld_i), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_kind(trace_kind),
    .trace_ts(trace_ts), .fifo_count(fifo_count), .overflow(overflow),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .illegal_cnt(illegal_cnt),
    .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Drive one retirement; queue the expected entry when a capture fits in the FIFO
  task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic vld,
                      input logic cap, input logic [1:0] kind);
    pc_i = pc;
    instr_i = ins;
    insn_vld_i = vld;
    if (cap && q.size() < DEPTH) q.push_back('{pc, ins, kind, cyc});
    if (en) cyc = clr ? '0 : cyc + 1;
    tick();
  endtask
  task automatic chk_head(input string tag);
    ent_t e;
    if (q.size() == 0) begin
      chk({tag, " queue"}, 1, 0);
      return;
    end
    e = q.pop_front();
    chk({tag, " valid"}, trace_valid, 1);
    chk({tag, " pc"}, trace_pc, e.pc);
    chk({tag, " instr"}, trace_instr, e.instr);
    chk({tag, " kind"}, trace_kind, e.kind);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    chk({tag, " ts"}, trace_ts, e.ts);
`else
    chk({tag, " ts"}, trace_ts, 0);
`endif
  endtask
  task automatic drain(input int n);
    trace_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk_head($sformatf("drain%0d", i));
      tick();
    end
    trace_ready = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst valid", trace_valid, 0);
    chk("rst count", fifo_count, 0);
    chk("rst ovf", overflow, 0);
    chk("rst cyc", cycle_cnt, 0);
    chk("rst drop", drop_cnt, 0);
    en = 1'b1;
    step(32'h0, 32'h13, 1, 1, 2'b00);
    step(32'h4, 32'h93, 1, 0, 2'b00);
    step(32'h8, 32'h113, 1, 0, 2'b00);
    step(32'hC, 32'h193, 1, 0, 2'b00);
    chk("seq cyc", cycle_cnt, 4);
    chk("seq instret", instret_cnt, 4);
    chk("seq illegal", illegal_cnt, 0);
    chk("seq count", fifo_count, 1);
    step(32'h40, 32'h6f, 1, 1, 2'b01);
    step(32'h10, 32'hFFFFFFFF, 0, 1, 2'b10);
    chk("ill cnt", illegal_cnt, 1);
    chk("ill instret", instret_cnt, 5);
    chk("ill cyc", cycle_cnt, 6);
    chk("ill count", fifo_count, 3);
    en = 1'b0;
    drain(3);
    chk("drain empty", trace_valid, 0);
    en = 1'b1;
    step(32'h200, 32'hA, 1, 1, 2'b00);
    for (int i = 0; i < 19; i++) step(32'h300 + 32'(i) * 32'h10, 32'hB00 + 32'(i), 1, 1, 2'b01);
    chk("full count", fifo_count, 16);
    chk("full ovf", overflow, 1);
    chk("full drop", drop_cnt, 4);
    trace_ready = 1'b1;
    chk_head("pp head");
    step(32'h800, 32'hC0DE, 1, 1, 2'b01);
    trace_ready = 1'b0;
    chk("pp count", fifo_count, 16);
    chk("pp drop", drop_cnt, 4);
    en = 1'b0;
    drain(16);
    chk("drain16 valid", trace_valid, 0);
    chk("drain16 count", fifo_count, 0);
    en = 1'b1;
    clr = 1'b1;
    step(32'h900, 32'hD, 1, 1, 2'b00);
    clr = 1'b0;
    chk("clr cyc", cycle_cnt, 0);
    chk("clr instret", instret_cnt, 0);
    chk("clr illegal", illegal_cnt, 0);
    chk("clr drop", drop_cnt, 0);
    chk("clr ovf", overflow, 0);
    chk("clr count", fifo_count, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step(32'h904 + 32'(i) * 32'h4, 32'h0, 1, 0, 2'b00);
    en = 1'b1;
    step(32'h100, 32'hE, 1, 1, 2'b00);
    chk("resync cyc", cycle_cnt, 1);
    chk("resync count", fifo_count, 2);
    en = 1'b0;
    drain(2);
    en = 1'b1;
    step(32'h500, 32'hF, 1, 1, 2'b01);
    chk("pre-rst count", fifo_count, 1);
    trace_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    trace_ready = 1'b0;
    q.delete();
    cyc = '0;
    chk("mid-rst count", fifo_count, 0);
    chk("mid-rst valid", trace_valid, 0);
    chk("mid-rst cyc", cycle_cnt, 0);
    step(32'h40, 32'h77, 1, 1, 2'b00);
    chk_head("post-rst head");
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
